dcache_array_nway: RTL and testbench
====================================

Name: dcache_array_nway

Overview:
- Parametrised N-way set-associative write-back data cache array; successor to the direct-mapped 128x64 array.
- Adds per-set round-robin replacement, correct dirty tracking (set on store, cleared on fill), and a victim buffer that drives evicted dirty lines to memory over a valid/ready handshake.
- Adds a flush engine that writes back every dirty line.
- Sits between the LSQ/dcache controller (read, store and fill ports) and the memory write path.

Parameters:
- IDX_BITS, 7, set index width; SETS = 2^IDX_BITS.
- TAG_BITS, 22, tag width.
- DATA_W, 64, line/data width.
- WAYS, 2, associativity; legal values 1, 2, 4.
- VB_DEPTH, 4, victim buffer entries; power of 2, at least 2.

Ports:
- clock, in, 1, system clock; all state updates on posedge.
- reset, in, 1, asynchronous, active-high; clears all control state immediately.
- rd_idx, in, IDX_BITS, read set.
- rd_tag, in, TAG_BITS, read tag.
- rd_data, out, DATA_W, data of the hitting way; 0 on miss.
- rd_hit, out, 1, some valid way in rd_idx matches rd_tag.
- st_en, in, 1, store request.
- st_idx, in, IDX_BITS, store set.
- st_tag, in, TAG_BITS, store tag.
- st_data, in, DATA_W, store data.
- st_hit, out, 1, store accepted this cycle.
- fill_en, in, 1, line fill from memory.
- fill_idx, in, IDX_BITS, fill set.
- fill_tag, in, TAG_BITS, fill tag.
- fill_data, in, DATA_W, fill data.
- fill_ready, out, 1, fill can be accepted this cycle.
- wb_valid, out, 1, victim buffer head valid.
- wb_ready, in, 1, memory accepts the head entry.
- wb_addr, out, TAG_BITS+IDX_BITS, {tag, idx} of the head entry.
- wb_data, out, DATA_W, data of the head entry.
- flush_req, in, 1, start flush (pulse).
- flush_busy, out, 1, flush in progress.
- flush_done, out, 1, one-cycle pulse when flush completes.

Behaviour:
- Storage per set/way: data, tag, valid, dirty. Each set also has a log2(WAYS)-bit round-robin pointer; for WAYS=1 the pointer is tied to 0.
- Reset (async):
  - Clears valid, dirty, pointers, victim buffer pointers/count and the FSM (to IDLE).
  - Data and tags are not reset.
  - All outputs read 0, except fill_ready = 1.
- Read: combinational from current state, zero latency. A fill or store in the same cycle is not visible until the next cycle.
- Store:
  - st_hit = st_en & tag hit in st_idx & !flush_busy & !(fill_en & fill_ready & fill_idx == st_idx).
  - On st_hit: the hitting way's data <= st_data and dirty <= 1.
  - A store that misses or is blocked changes no state; the controller must retry.
- fill_ready = !flush_busy & (vb_count < VB_DEPTH). fill_en while fill_ready = 0 is ignored.
- Fill accepted (fill_en & fill_ready):
  - If fill_tag already hits a way in the set, that way is overwritten in place; no eviction, pointer unchanged.
  - Otherwise the target way is the lowest-numbered invalid way if one exists. If none is invalid, the target is the way at the set's pointer, and the pointer advances by 1 mod WAYS.
  - If the target way is valid and dirty, {old tag, idx, old data} is pushed into the victim buffer in the same edge.
  - Target way: data/tag <= fill values, valid <= 1, dirty <= 0.
- Victim buffer:
  - FIFO, first-in first-out; wb_* show the head entry; wb_valid = (count != 0).
  - A pop happens on wb_valid & wb_ready.
  - Push and pop in the same cycle are both legal; count is unchanged.
  - Overflow cannot occur because fill_ready gates pushes.
- Flush FSM, states IDLE, WALK, DRAIN, DONE:
  - IDLE -> WALK on flush_req. flush_req is ignored in any other state.
  - WALK: a counter steps over set*WAYS + way, from 0 to SETS*WAYS-1, one line per cycle.
    - A dirty valid line is pushed and its dirty bit cleared; valid is retained.
    - The counter stalls while the buffer is full and the current line needs a push.
    - Clean or invalid lines advance without a push.
  - After the last line -> DRAIN. DRAIN stays until vb_count == 0, then -> DONE.
  - DONE: flush_done = 1 for one cycle -> IDLE.
  - flush_busy = 1 in WALK and DRAIN.
- Reset asserted mid-flush or mid-drain returns the FSM to IDLE and discards buffered victims.

Test Plan:
- WAYS=2, reset, then fill idx 5 tag 0x1 data 0xA -> next cycle rd idx5/tag1 gives rd_hit=1, rd_data=0xA; wb_valid=0.
- Store idx5 tag1 data 0xB, then fill idx5 tag2, then fill idx5 tag3 -> third fill evicts way0 (pointer 0): wb_valid=1, wb_addr={0x1,5}, wb_data=0xB.
- Store to a missing tag -> st_hit=0, and a following read shows no change.
- Store and fill both to idx 9 in the same cycle -> st_hit=0; fill applied.
- VB_DEPTH=2, wb_ready=0, three dirty evictions -> fill_ready=0 after the second eviction; third fill ignored until one wb_ready handshake.
- Dirty lines at (3,0) and (70,1), then flush_req with wb_ready=1 -> exactly two wb transfers in walk order, then flush_done pulse.
- Reset asserted during WALK -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/dcache_array_nway.sv
// dcache_array_nway
//   N-way set-associative write-back data cache array with per-set
//   round-robin replacement, dirty tracking, a victim FIFO toward memory
//   and a flush engine that writes back every dirty line.
//
// Ports
//   clock, reset                         clock / async active-high reset
//   rd_idx, rd_tag -> rd_data, rd_hit    combinational lookup (0 on miss)
//   st_en/idx/tag/data -> st_hit         store into a hitting line
//   fill_en/idx/tag/data, fill_ready     line fill from memory
//   wb_valid/ready/addr/data             victim FIFO head, addr = {tag, idx}
//   flush_req -> flush_busy, flush_done  write back all dirty lines
module dcache_array_nway #(
  parameter int IDX_BITS = 7,
  parameter int TAG_BITS = 22,
  parameter int DATA_W   = 64,
  parameter int WAYS     = 2,
  parameter int VB_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [IDX_BITS-1:0]          rd_idx,
  input  logic [TAG_BITS-1:0]          rd_tag,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_hit,
  input  logic                         st_en,
  input  logic [IDX_BITS-1:0]          st_idx,
  input  logic [TAG_BITS-1:0]          st_tag,
  input  logic [DATA_W-1:0]            st_data,
  output logic                         st_hit,
  input  logic                         fill_en,
  input  logic [IDX_BITS-1:0]          fill_idx,
  input  logic [TAG_BITS-1:0]          fill_tag,
  input  logic [DATA_W-1:0]            fill_data,
  output logic                         fill_ready,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [TAG_BITS+IDX_BITS-1:0] wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  input  logic                         flush_req,
  output logic                         flush_busy,
  output logic                         flush_done
);

  localparam int SETS = 1 << IDX_BITS;
  localparam int LW   = $clog2(WAYS);
  localparam int PW   = (WAYS > 1) ? LW : 1;
  localparam int CW   = IDX_BITS + LW;
  localparam int VBW  = $clog2(VB_DEPTH);
  localparam int AW   = TAG_BITS + IDX_BITS;
  localparam logic [VBW:0]  VB_FULL  = (VBW+1)'(VB_DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(SETS*WAYS - 1);

  typedef enum logic [1:0] {IDLE, WALK, DRAIN, DONE} fstate_t;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } vb_ent_t;

  // line storage; data/tags are never reset, valid/dirty/pointers are
  logic [DATA_W-1:0]   data_mem [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [SETS-1:0][PW-1:0]   rr_ptr_q;

  vb_ent_t        vb_mem [VB_DEPTH];
  logic [VBW-1:0] vb_wr_q, vb_rd_q;
  logic [VBW:0]   vb_count_q;

  fstate_t        state_q, state_d;
  logic [CW-1:0]  fl_cnt_q;
  logic [IDX_BITS-1:0] walk_idx;
  logic [PW-1:0]  walk_way;
  logic           walk_need, walk_adv, walk_push;

  logic [WAYS-1:0] rd_hitv, st_hitv, fl_hitv;
  logic [PW-1:0]   st_way, fl_way, fl_hit_way, fl_inv_way;
  logic            fl_hit, fl_any_inv, fill_acc, fill_push, push, pop;
  vb_ent_t         push_ent;

  // ---------------- tag compare per way ----------------
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign rd_hitv[w] = valid_q[rd_idx][w]   && (tag_mem[rd_idx][w]   == rd_tag);
    assign st_hitv[w] = valid_q[st_idx][w]   && (tag_mem[st_idx][w]   == st_tag);
    assign fl_hitv[w] = valid_q[fill_idx][w] && (tag_mem[fill_idx][w] == fill_tag);
  end

  // at most one way can match a tag (fills of a present tag go in place)
  always_comb begin
    rd_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (rd_hitv[w]) rd_data = rd_data | data_mem[rd_idx][w];
  end
  assign rd_hit = |rd_hitv;

  // ---------------- way selection ----------------
  always_comb begin
    st_way     = '0;
    fl_hit_way = '0;
    fl_inv_way = '0;
    fl_any_inv = 1'b0;
    // downward scans so the lowest-numbered match wins
    for (int w = WAYS-1; w >= 0; w--) begin
      if (st_hitv[w]) st_way = PW'(w);
      if (fl_hitv[w]) fl_hit_way = PW'(w);
      if (!valid_q[fill_idx][w]) begin
        fl_inv_way = PW'(w);
        fl_any_inv = 1'b1;
      end
    end
  end

  assign fl_hit     = |fl_hitv;
  assign fl_way     = fl_hit ? fl_hit_way : (fl_any_inv ? fl_inv_way : rr_ptr_q[fill_idx]);
  assign fill_ready = !flush_busy && (vb_count_q < VB_FULL);
  assign fill_acc   = fill_en && fill_ready;
  assign fill_push  = fill_acc && !fl_hit && valid_q[fill_idx][fl_way] && dirty_q[fill_idx][fl_way];
  assign st_hit     = st_en && (|st_hitv) && !flush_busy && !(fill_acc && (fill_idx == st_idx));

  // ---------------- flush walk ----------------
  if (WAYS > 1) begin : g_wsplit
    assign walk_way = fl_cnt_q[LW-1:0];
    assign walk_idx = fl_cnt_q[CW-1:LW];
  end else begin : g_wflat
    assign walk_way = '0;
    assign walk_idx = fl_cnt_q;
  end

  assign walk_need = valid_q[walk_idx][walk_way] && dirty_q[walk_idx][walk_way];
  assign walk_push = walk_adv && walk_need;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flush_busy = 1'b0;
    flush_done = 1'b0;
    walk_adv   = 1'b0;
    case (state_q)
      IDLE:  if (flush_req) state_d = WALK;
      WALK: begin
        flush_busy = 1'b1;
        walk_adv   = !walk_need || (vb_count_q != VB_FULL);
        if (walk_adv && (fl_cnt_q == LAST_CNT)) state_d = DRAIN;
      end
      DRAIN: begin
        flush_busy = 1'b1;
        if (vb_count_q == '0) state_d = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 fl_cnt_q <= '0;
    else if (state_q == IDLE)  fl_cnt_q <= '0;
    else if (walk_adv)         fl_cnt_q <= fl_cnt_q + 1'b1;
  end

  // ---------------- line state ----------------
  // store and fill never touch the same set in one cycle (st_hit blocks it),
  // and the walk only runs while stores and fills are locked out
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (st_hit) dirty_q[st_idx][st_way] <= 1'b1;
      if (fill_acc) begin
        valid_q[fill_idx][fl_way] <= 1'b1;
        dirty_q[fill_idx][fl_way] <= 1'b0;
        if ((WAYS > 1) && !fl_hit && !fl_any_inv)
          rr_ptr_q[fill_idx] <= rr_ptr_q[fill_idx] + 1'b1;
      end
      if (walk_push) dirty_q[walk_idx][walk_way] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (st_hit) data_mem[st_idx][st_way] <= st_data;
    if (fill_acc) begin
      data_mem[fill_idx][fl_way] <= fill_data;
      tag_mem[fill_idx][fl_way]  <= fill_tag;
    end
  end

  // ---------------- victim FIFO ----------------
  assign push = fill_push || walk_push;
  assign pop  = wb_valid && wb_ready;

  always_comb begin
    if (walk_push) begin
      push_ent.addr = {tag_mem[walk_idx][walk_way], walk_idx};
      push_ent.data = data_mem[walk_idx][walk_way];
    end else begin
      push_ent.addr = {tag_mem[fill_idx][fl_way], fill_idx};
      push_ent.data = data_mem[fill_idx][fl_way];
    end
  end

  always_ff @(posedge clock) begin
    if (push) vb_mem[vb_wr_q] <= push_ent;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vb_wr_q    <= '0;
      vb_rd_q    <= '0;
      vb_count_q <= '0;
    end else begin
      if (push) vb_wr_q <= vb_wr_q + 1'b1;
      if (pop)  vb_rd_q <= vb_rd_q + 1'b1;
      case ({push, pop})
        2'b10:   vb_count_q <= vb_count_q + 1'b1;
        2'b01:   vb_count_q <= vb_count_q - 1'b1;
        default: vb_count_q <= vb_count_q;
      endcase
    end
  end

  // head is gated so stale (unreset) entries never show on the port
  assign wb_valid = (vb_count_q != '0);
  assign wb_addr  = wb_valid ? vb_mem[vb_rd_q].addr : '0;
  assign wb_data  = wb_valid ? vb_mem[vb_rd_q].data : '0;

endmodule

// File: tb/tb_dcache_array_nway.sv
module tb_dcache_array_nway;
  localparam int IB = 7, TB = 22, DW = 64, WAYS = 2, VBD = 2;

  logic clock, reset;
  logic [IB-1:0] rd_idx, st_idx, fill_idx;
  logic [TB-1:0] rd_tag, st_tag, fill_tag;
  logic [DW-1:0] rd_data, st_data, fill_data, wb_data;
  logic rd_hit, st_en, st_hit, fill_en, fill_ready, wb_valid, wb_ready;
  logic [TB+IB-1:0] wb_addr;
  logic flush_req, flush_busy, flush_done;

  int n_cmp = 0, n_err = 0;

  dcache_array_nway #(.IDX_BITS(IB), .TAG_BITS(TB), .DATA_W(DW), .WAYS(WAYS), .VB_DEPTH(VBD)) dut (
    .clock(clock), .reset(reset),
    .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_data(rd_data), .rd_hit(rd_hit),
    .st_en(st_en), .st_idx(st_idx), .st_tag(st_tag), .st_data(st_data), .st_hit(st_hit),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data),
    .fill_ready(fill_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc;
    @(posedge clock); #1;
  endtask

  task automatic do_fill(input logic [IB-1:0] i, input logic [TB-1:0] t, input logic [DW-1:0] d);
    fill_en = 1'b1; fill_idx = i; fill_tag = t; fill_data = d;
    cyc;
    fill_en = 1'b0;
  endtask

  task automatic do_store(input logic [IB-1:0] i, input logic [TB-1:0] t, input logic [DW-1:0] d);
    st_en = 1'b1; st_idx = i; st_tag = t; st_data = d;
    cyc;
    st_en = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if (rd_hit !== 1'b0)     begin n_err++; $display("FAIL reset_rd_hit: got %b want 0", rd_hit); end
    n_cmp++; if (rd_data !== '0)      begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_cmp++; if (st_hit !== 1'b0)     begin n_err++; $display("FAIL reset_st_hit: got %b want 0", st_hit); end
    n_cmp++; if (fill_ready !== 1'b1) begin n_err++; $display("FAIL reset_fill_ready: got %b want 1", fill_ready); end
    n_cmp++; if (wb_valid !== 1'b0)   begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    n_cmp++; if (wb_addr !== '0)      begin n_err++; $display("FAIL reset_wb_addr: got %h want 0", wb_addr); end
    n_cmp++; if (flush_busy !== 1'b0 || flush_done !== 1'b0)
      begin n_err++; $display("FAIL reset_flush: got busy=%b done=%b want 0 0", flush_busy, flush_done); end
    reset = 1'b0;
    cyc;
  endtask

  task automatic test_fill_read;
    rd_idx = 7'd5; rd_tag = 22'h1;
    fill_en = 1'b1; fill_idx = 7'd5; fill_tag = 22'h1; fill_data = 64'hA;
    #1;
    n_cmp++; if (rd_hit !== 1'b0) begin n_err++; $display("FAIL fill_same_cycle_hit: got %b want 0", rd_hit); end
    cyc;
    fill_en = 1'b0;
    n_cmp++; if (rd_hit !== 1'b1)   begin n_err++; $display("FAIL fill_rd_hit: got %b want 1", rd_hit); end
    n_cmp++; if (rd_data !== 64'hA) begin n_err++; $display("FAIL fill_rd_data: got %h want a", rd_data); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL fill_wb_valid: got %b want 0", wb_valid); end
  endtask

  task automatic test_evict;
    st_en = 1'b1; st_idx = 7'd5; st_tag = 22'h1; st_data = 64'hB;
    #1;
    n_cmp++; if (st_hit !== 1'b1) begin n_err++; $display("FAIL evict_st_hit: got %b want 1", st_hit); end
    cyc;
    st_en = 1'b0;
    do_fill(7'd5, 22'h2, 64'h2C);
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL evict_fill2_wb_valid: got %b want 0", wb_valid); end
    do_fill(7'd5, 22'h3, 64'h3C);
    n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL evict_wb_valid: got %b want 1", wb_valid); end
    n_cmp++; if (wb_addr !== {22'h1, 7'd5}) begin n_err++; $display("FAIL evict_wb_addr: got %h want %h", wb_addr, {22'h1, 7'd5}); end
    n_cmp++; if (wb_data !== 64'hB) begin n_err++; $display("FAIL evict_wb_data: got %h want b", wb_data); end
    rd_idx = 7'd5; rd_tag = 22'h1; #1;
    n_cmp++; if (rd_hit !== 1'b0) begin n_err++; $display("FAIL evict_old_tag_hit: got %b want 0", rd_hit); end
    rd_tag = 22'h3; #1;
    n_cmp++; if (rd_hit !== 1'b1 || rd_data !== 64'h3C)
      begin n_err++; $display("FAIL evict_new_line: got hit=%b data=%h want 1 3c", rd_hit, rd_data); end
    wb_ready = 1'b1;
    cyc;
    wb_ready = 1'b0;
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL evict_pop_wb_valid: got %b want 0", wb_valid); end
  endtask

  task automatic test_store_miss;
    st_en = 1'b1; st_idx = 7'd5; st_tag = 22'h7; st_data = 64'hDEAD;
    #1;
    n_cmp++; if (st_hit !== 1'b0) begin n_err++; $display("FAIL miss_st_hit: got %b want 0", st_hit); end
    cyc;
    st_en = 1'b0;
    rd_idx = 7'd5; rd_tag = 22'h7; #1;
    n_cmp++; if (rd_hit !== 1'b0) begin n_err++; $display("FAIL miss_rd_hit: got %b want 0", rd_hit); end
    rd_tag = 22'h3; #1;
    n_cmp++; if (rd_data !== 64'h3C) begin n_err++; $display("FAIL miss_other_line: got %h want 3c", rd_data); end
  endtask

  task automatic test_store_fill_conflict;
    do_fill(7'd9, 22'h4, 64'h44);
    st_en = 1'b1; st_idx = 7'd9; st_tag = 22'h4; st_data = 64'h99;
    fill_en = 1'b1; fill_idx = 7'd9; fill_tag = 22'h5; fill_data = 64'h55;
    #1;
    n_cmp++; if (st_hit !== 1'b0) begin n_err++; $display("FAIL conflict_st_hit: got %b want 0", st_hit); end
    cyc;
    st_en = 1'b0; fill_en = 1'b0;
    rd_idx = 7'd9; rd_tag = 22'h4; #1;
    n_cmp++; if (rd_hit !== 1'b1 || rd_data !== 64'h44)
      begin n_err++; $display("FAIL conflict_store_blocked: got hit=%b data=%h want 1 44", rd_hit, rd_data); end
    rd_tag = 22'h5; #1;
    n_cmp++; if (rd_hit !== 1'b1 || rd_data !== 64'h55)
      begin n_err++; $display("FAIL conflict_fill_applied: got hit=%b data=%h want 1 55", rd_hit, rd_data); end
  endtask

  task automatic test_vb_full;
    wb_ready = 1'b0;
    do_fill(7'd20, 22'h10, 64'h0);
    do_fill(7'd20, 22'h11, 64'h0);
    do_store(7'd20, 22'h10, 64'h100);
    do_store(7'd20, 22'h11, 64'h101);
    do_fill(7'd20, 22'h12, 64'h12);   // evicts tag 0x10 (pointer 0)
    n_cmp++; if (fill_ready !== 1'b1) begin n_err++; $display("FAIL vb_one_fill_ready: got %b want 1", fill_ready); end
    do_fill(7'd20, 22'h13, 64'h13);   // evicts tag 0x11 (pointer 1)
    n_cmp++; if (fill_ready !== 1'b0) begin n_err++; $display("FAIL vb_full_fill_ready: got %b want 0", fill_ready); end
    do_store(7'd20, 22'h12, 64'h102);
    do_fill(7'd20, 22'h14, 64'h14);   // must be ignored
    rd_idx = 7'd20; rd_tag = 22'h14; #1;
    n_cmp++; if (rd_hit !== 1'b0) begin n_err++; $display("FAIL vb_full_fill_ignored: got hit=%b want 0", rd_hit); end
    rd_tag = 22'h12; #1;
    n_cmp++; if (rd_data !== 64'h102) begin n_err++; $display("FAIL vb_full_line_kept: got %h want 102", rd_data); end
    n_cmp++; if (wb_addr !== {22'h10, 7'd20} || wb_data !== 64'h100)
      begin n_err++; $display("FAIL vb_head0: got %h/%h want %h/100", wb_addr, wb_data, {22'h10, 7'd20}); end
    wb_ready = 1'b1;
    cyc;
    wb_ready = 1'b0;
    n_cmp++; if (fill_ready !== 1'b1) begin n_err++; $display("FAIL vb_pop_fill_ready: got %b want 1", fill_ready); end
    do_fill(7'd20, 22'h14, 64'h14);   // evicts dirty tag 0x12
    n_cmp++; if (fill_ready !== 1'b0) begin n_err++; $display("FAIL vb_refull_fill_ready: got %b want 0", fill_ready); end
    n_cmp++; if (wb_addr !== {22'h11, 7'd20} || wb_data !== 64'h101)
      begin n_err++; $display("FAIL vb_head1: got %h/%h want %h/101", wb_addr, wb_data, {22'h11, 7'd20}); end
    wb_ready = 1'b1;
    cyc;
    n_cmp++; if (wb_addr !== {22'h12, 7'd20} || wb_data !== 64'h102)
      begin n_err++; $display("FAIL vb_head2: got %h/%h want %h/102", wb_addr, wb_data, {22'h12, 7'd20}); end
    cyc;
    wb_ready = 1'b0;
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL vb_drained: got %b want 0", wb_valid); end
  endtask

  task automatic test_flush;
    logic [TB+IB-1:0] a [4];
    logic [DW-1:0]    d [4];
    int xfers;
    bit seen_done;
    do_fill(7'd3, 22'h30, 64'h300);
    do_store(7'd3, 22'h30, 64'h333);
    do_fill(7'd70, 22'h40, 64'h400);
    do_fill(7'd70, 22'h41, 64'h410);
    do_store(7'd70, 22'h41, 64'h444);
    wb_ready = 1'b1;
    flush_req = 1'b1;
    cyc;
    flush_req = 1'b0;
    n_cmp++; if (flush_busy !== 1'b1 || fill_ready !== 1'b0)
      begin n_err++; $display("FAIL flush_start: got busy=%b fill_ready=%b want 1 0", flush_busy, fill_ready); end
    xfers = 0; seen_done = 1'b0;
    for (int c = 0; c < 600 && !seen_done; c++) begin
      if (wb_valid && wb_ready) begin
        if (xfers < 4) begin a[xfers] = wb_addr; d[xfers] = wb_data; end
        xfers++;
      end
      if (flush_done) seen_done = 1'b1;
      else cyc;
    end
    n_cmp++; if (!seen_done) begin n_err++; $display("FAIL flush_timeout: flush_done not seen within 600 cycles"); end
    n_cmp++; if (xfers != 2) begin n_err++; $display("FAIL flush_xfers: got %0d want 2", xfers); end
    if (xfers >= 2) begin
      n_cmp++; if (a[0] !== {22'h30, 7'd3} || d[0] !== 64'h333)
        begin n_err++; $display("FAIL flush_xfer0: got %h/%h want %h/333", a[0], d[0], {22'h30, 7'd3}); end
      n_cmp++; if (a[1] !== {22'h41, 7'd70} || d[1] !== 64'h444)
        begin n_err++; $display("FAIL flush_xfer1: got %h/%h want %h/444", a[1], d[1], {22'h41, 7'd70}); end
    end
    cyc;
    wb_ready = 1'b0;
    n_cmp++; if (flush_done !== 1'b0 || flush_busy !== 1'b0)
      begin n_err++; $display("FAIL flush_end: got done=%b busy=%b want 0 0", flush_done, flush_busy); end
    rd_idx = 7'd3; rd_tag = 22'h30; #1;
    n_cmp++; if (rd_hit !== 1'b1 || rd_data !== 64'h333)
      begin n_err++; $display("FAIL flush_valid_kept: got hit=%b data=%h want 1 333", rd_hit, rd_data); end
  endtask

  task automatic test_reset_mid_walk;
    do_store(7'd3, 22'h30, 64'h555);
    wb_ready = 1'b0;
    flush_req = 1'b1;
    cyc;
    flush_req = 1'b0;
    repeat (15) cyc;
    n_cmp++; if (flush_busy !== 1'b1 || wb_valid !== 1'b1 || wb_addr !== {22'h30, 7'd3})
      begin n_err++; $display("FAIL walk_state: got busy=%b wb_valid=%b addr=%h want 1 1 %h", flush_busy, wb_valid, wb_addr, {22'h30, 7'd3}); end
    rd_idx = 7'd3; rd_tag = 22'h30;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (flush_busy !== 1'b0 || flush_done !== 1'b0)
      begin n_err++; $display("FAIL arst_flush: got busy=%b done=%b want 0 0", flush_busy, flush_done); end
    n_cmp++; if (wb_valid !== 1'b0 || wb_addr !== '0 || wb_data !== '0)
      begin n_err++; $display("FAIL arst_wb: got valid=%b addr=%h data=%h want 0 0 0", wb_valid, wb_addr, wb_data); end
    n_cmp++; if (fill_ready !== 1'b1) begin n_err++; $display("FAIL arst_fill_ready: got %b want 1", fill_ready); end
    n_cmp++; if (rd_hit !== 1'b0 || rd_data !== '0)
      begin n_err++; $display("FAIL arst_rd: got hit=%b data=%h want 0 0", rd_hit, rd_data); end
    cyc;
    reset = 1'b0;
    cyc;
    n_cmp++; if (flush_busy !== 1'b0 || wb_valid !== 1'b0)
      begin n_err++; $display("FAIL arst_release: got busy=%b wb_valid=%b want 0 0", flush_busy, wb_valid); end
  endtask

  initial begin
    reset = 1'b1;
    rd_idx = '0; rd_tag = '0;
    st_en = 1'b0; st_idx = '0; st_tag = '0; st_data = '0;
    fill_en = 1'b0; fill_idx = '0; fill_tag = '0; fill_data = '0;
    wb_ready = 1'b0; flush_req = 1'b0;
    test_reset;
    test_fill_read;
    test_evict;
    test_store_miss;
    test_store_fill_conflict;
    test_vb_full;
    test_flush;
    test_reset_mid_walk;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
